// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// Frames go out LSB-first on TX, one bit per BAUD_DIV clocks, with one idle cycle between frames.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 43,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx_done,
    output logic       TX
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [PW:0]   PTR_ONE   = (PW + 1)'(1);

    typedef enum logic {IDLE, XMIT} state_t;
    state_t state, state_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [9:0]    shift_reg;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic          wr_en, load, bit_end, frame_end;

    // Host handshake: a byte is taken on every edge where trmt is high and full is low;
    // a strobe while full is dropped without any trace, so the host must watch full.
    assign wr_en = trmt && !full;

    // The pointer MSB toggles on each wrap, so equal low bits mean empty or full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign busy      = (state == XMIT);
    assign bit_end   = (state == XMIT) && (baud_cnt == BAUD_LAST);
    assign frame_end = bit_end && (bit_cnt == 4'd9);
    assign TX        = shift_reg[0];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    state_nxt = XMIT;
                end
            end
            XMIT: begin
                if (frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[PW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_done   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_done <= frame_end;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (load) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                shift_reg <= {1'b1, mem[rd_ptr[PW-1:0]], 1'b0};
                baud_cnt  <= '0;
                bit_cnt   <= '0;
            end else if (state == XMIT) begin
                // Shifting in ones leaves the line high once the stop bit has gone out.
                if (bit_end) begin
                    baud_cnt  <= '0;
                    shift_reg <= {1'b1, shift_reg[9:1]};
                    bit_cnt   <= bit_cnt + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt + BAUD_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed an expected-byte queue, and a line
// monitor decodes every frame on TX and pops the queue to compare.
module tb_uart_tx_fifo;
    localparam int BAUD_DIV   = 43;
    localparam int FIFO_DEPTH = 4;
    localparam int HALF       = BAUD_DIV / 2;
    localparam int PITCH      = 10 * BAUD_DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       full, empty, busy, tx_done, TX;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    uart_tx_fifo #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .trmt(trmt),
        .full(full), .empty(empty), .busy(busy), .tx_done(tx_done), .TX(TX)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // line monitor: samples each bit mid-period and compares against the scoreboard
    int         mon_cnt = 0;
    logic       mon_act = 1'b0;
    logic [9:0] mon_sh = '1;
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && TX === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                start_q.push_back(cyc);
            end
            if (mon_act) begin
                if (mon_cnt % BAUD_DIV == HALF) mon_sh[mon_cnt / BAUD_DIV] = TX;
                if (mon_cnt == 9 * BAUD_DIV + HALF) begin
                    mon_act = 1'b0;
                    check("frame_start_bit", 32'(mon_sh[0]), 32'd0);
                    check("frame_stop_bit", 32'(mon_sh[9]), 32'd1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_expected: got byte 0x%0h, expected no frame", mon_sh[8:1]);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (mon_sh[8:1] !== e) begin
                            errors++;
                            $display("FAIL frame_data: got 0x%0h, expected 0x%0h", mon_sh[8:1], e);
                        end
                    end
                end
                mon_cnt++;
            end
        end
    end

    // driver tasks
    task automatic write_byte(input logic [7:0] b, input bit expect_sent);
        tx_data = b;
        trmt    = 1'b1;
        if (expect_sent) exp_q.push_back(b);
        @(negedge clk);
        trmt = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, input string name);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_busy(input int limit, input string name);
        int n = 0;
        while (busy !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd1);
    endtask

    logic [9:0] a5_seq;
    logic [7:0] burst [5];
    logic [7:0] wrap [10];
    int base, bad, n, idx, grp;

    initial begin
        a5_seq = 10'b1101001010;
        burst  = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
        wrap   = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A};

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx_done", 32'(tx_done), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single byte with exact bit timing
        tx_data = 8'hA5;
        trmt    = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        trmt = 1'b0;
        check("single_empty_after_write", 32'(empty), 32'd0);
        check("single_tx_before_load", 32'(TX), 32'd1);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < BAUD_DIV; c++) begin
                @(negedge clk);
                if (TX !== a5_seq[b] || busy !== 1'b1) bad++;
            end
            check($sformatf("single_level_%0d_bad_cycles", b), 32'(bad), 32'd0);
        end
        @(negedge clk);
        check("single_tx_done_pulse", 32'(tx_done), 32'd1);
        check("single_busy_fall", 32'(busy), 32'd0);
        check("single_tx_idle", 32'(TX), 32'd1);
        @(negedge clk);
        check("single_tx_done_width", 32'(tx_done), 32'd0);
        check("single_done_count", 32'(done_cnt), 32'd1);
        repeat (3) @(negedge clk);

        // burst and overflow behind an in-flight lead frame
        base = done_cnt;
        start_q.delete();
        write_byte(8'hC3, 1'b1);
        wait_busy(20, "burst_lead_busy");
        for (int i = 0; i < 5; i++) begin
            tx_data = burst[i];
            trmt    = 1'b1;
            if (i < 4) exp_q.push_back(burst[i]);
            @(negedge clk);
            check($sformatf("burst_full_after_write_%0d", i + 1), 32'(full), (i >= 3) ? 32'd1 : 32'd0);
        end
        trmt = 1'b0;
        n = 0;
        while (full === 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("burst_full_falls", 32'(full), 32'd0);
        check("burst_busy_at_pop", 32'(busy), 32'd1);
        check("burst_empty_after_pop", 32'(empty), 32'd0);
        wait_done(base + 5, 5 * PITCH, "burst_done_count");
        repeat (5) @(negedge clk);
        check("burst_done_total", 32'(done_cnt), 32'(base + 5));
        check("burst_queue_drained", 32'(exp_q.size()), 32'd0);
        check("burst_empty_end", 32'(empty), 32'd1);
        check("burst_frame_starts", 32'(start_q.size()), 32'd5);
        for (int i = 1; i < start_q.size(); i++)
            check($sformatf("burst_pitch_%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(PITCH));

        // wrap-around: ten bytes in groups of three
        base = done_cnt;
        idx  = 0;
        for (grp = 0; grp < 4; grp++) begin
            for (int k = 0; k < ((grp < 3) ? 3 : 1); k++) begin
                tx_data = wrap[idx];
                trmt    = 1'b1;
                exp_q.push_back(wrap[idx]);
                idx++;
                @(negedge clk);
            end
            trmt = 1'b0;
            wait_done(base + idx, 3 * PITCH + 50, $sformatf("wrap_group_%0d_done", grp));
            repeat (3) @(negedge clk);
        end
        check("wrap_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_empty_end", 32'(empty), 32'd1);

        // write on the same edge as a pop from a full FIFO
        base = done_cnt;
        write_byte(8'hE0, 1'b1);
        wait_busy(20, "popedge_lead_busy");
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'hD1 + 8'(i);
            trmt    = 1'b1;
            exp_q.push_back(8'hD1 + 8'(i));
            @(negedge clk);
        end
        trmt = 1'b0;
        check("popedge_full_before", 32'(full), 32'd1);
        n = 0;
        while (tx_done !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("popedge_lead_done", 32'(tx_done), 32'd1);
        tx_data = 8'h77;
        trmt    = 1'b1;
        @(negedge clk);
        check("popedge_full_after_pop", 32'(full), 32'd0);
        check("popedge_busy_after_pop", 32'(busy), 32'd1);
        exp_q.push_back(8'h77);
        @(negedge clk);
        trmt = 1'b0;
        check("popedge_full_after_retry", 32'(full), 32'd1);
        wait_done(base + 6, 6 * PITCH, "popedge_done_count");
        repeat (5) @(negedge clk);
        check("popedge_done_total", 32'(done_cnt), 32'(base + 6));
        check("popedge_queue_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of data bit 3 with two bytes queued
        base = done_cnt;
        write_byte(8'hF0, 1'b0);
        write_byte(8'h0F, 1'b0);
        write_byte(8'hA9, 1'b0);
        repeat (4 * BAUD_DIV + 10) @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        check("rstmid_empty_before", 32'(empty), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_tx_high", 32'(TX), 32'd1);
        check("rstmid_empty", 32'(empty), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_tx_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rstmid_line_quiet_cycles", 32'(bad), 32'd0);
        check("rstmid_no_tx_done", 32'(done_cnt), 32'(base));
        check("rstmid_empty_after", 32'(empty), 32'd1);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
